stack_ctrl: RTL
===============

# stack_ctrl

Sequencer for the data memory's stack port: owns the stack pointer and the data memory's address-select, data-select and write-enable controls. Executes PUSH, POP, CALL and RET requests from the instruction decoder, and arbitrates them against R0-addressed register stores. Guards against stack overflow and underflow. Sits between the decoder/PC logic and the data memory; the data memory's SP, select and write inputs are driven only by this block.

## Interface
- `SP_TOP`, 8'hFF: SP value after reset; first PUSH writes here.
- `DEPTH`, 64: maximum stacked entries; legal range 1..SP_TOP+1.
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input 1: stack request present.
- `req_op` input 2: 0=PUSH (RN), 1=POP, 2=CALL (NPC), 3=RET.
- `req_ready` output 1: block can accept a stack request; high only in IDLE.
- `st_wr` input 1: decoder requests the store mem[R0] <= RN.
- `st_ready` output 1: the store is performed this cycle.
- `mem_rdata` input 8: data memory read data.
- `sp` output 8: stack pointer, which drives the memory's SP input.
- `mem_wr` output 1: memory write enable.
- `sel_sp` output 1: memory address select; 1=SP, 0=R0.
- `sel_rn` output 1: memory write-data select; 1=RN, 0=NPC.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: qualifies `done`; the operation was rejected.
- `pop_data` output 8: popped value; valid while `done` is high for POP/RET.
- `pc_load` output 1: pulses with `done` on a successful RET.
- `ovf` / `udf` output 1 each: sticky overflow / underflow flags.
- `err_clr` input 1: clears `ovf` and `udf`.

## Operation
- Stack is empty-descending: `sp` points at the next free slot. A `depth` counter (0..DEPTH) tracks occupancy. Full means depth==DEPTH; empty means depth==0.
- FSM states:
  - IDLE: `req_ready`=1.
  - POP_RD: `req_ready`=0.
- A request is accepted when `req_valid` and `req_ready` are both high.
- Accepted PUSH/CALL, not full:
  - Same cycle, combinationally: `mem_wr`=1, `sel_sp`=1, `sel_rn` = (op==PUSH).
  - At the edge, mem[sp] is written, then sp <= sp-1 and depth <= depth+1.
  - FSM stays in IDLE.
- Accepted POP/RET, not empty:
  - At the edge, sp <= sp+1, depth <= depth-1, and the FSM goes to POP_RD.
  - In POP_RD: `sel_sp`=1 and `mem_wr`=0; `mem_rdata` is registered into `pop_data` at the edge, then the FSM returns to IDLE.
- Rejected operations:
  - PUSH/CALL when full: no write, sp and depth unchanged, `ovf` set.
  - POP/RET when empty: sp and depth unchanged, `udf` set, `pop_data` holds its value, no `pc_load`, FSM stays in IDLE.
  - Either case: `done`=`err`=1 in the next cycle.
- Stores:
  - `st_ready` = `st_wr` & IDLE & !`req_valid`; a stack request wins any conflict.
  - When `st_ready` is high: `mem_wr`=1, `sel_sp`=0, `sel_rn`=1.
  - An un-granted store must be held by the decoder.
- Default drive with no grant: `sel_sp`=0, `sel_rn`=0, `mem_wr`=0.
- Sticky flags: same-cycle set and `err_clr` → set wins.
- sp arithmetic is mod 256. Wrap cannot occur when DEPTH is within its legal range.

## Timing
- Reset values: sp=SP_TOP, depth=0, FSM=IDLE, and `done`, `err`, `pc_load`, `ovf`, `udf`, `pop_data`=0. Combinational outputs follow from IDLE with no request: `req_ready`=1, `mem_wr`=0, `sel_sp`=0, `sel_rn`=0.
- PUSH/CALL accepted at cycle T:
  - Write commits at the end of T; `done`=1 at T+1.
  - `req_ready` stays high, so one push per cycle is sustainable.
- POP/RET accepted at cycle T:
  - Memory read at T+1.
  - At T+2: `done`=1, `pop_data` valid, `pc_load`=1 if RET, and `req_ready`=1 again.
- `done`, `err` and `pc_load` are registered single-cycle pulses.
- Reset asserted mid-POP: immediate return to reset values, no `done`, no write.

## Structure
- Shared package `stack_pkg`: op encoding constants (OP_PUSH, OP_POP, OP_CALL, OP_RET) and the FSM state type.
- One sub-module, `stack_ptr`: the sp/depth registers with increment/decrement and full/empty outputs.
- The FSM and output muxing stay in `stack_ctrl`.

## Test plan
- Reset, then PUSH with RN=8'hA5 → at the push cycle `mem_wr`=1, `sel_sp`=1, `sel_rn`=1, sp=FF; next cycle sp=FE, `done`=1, `err`=0.
- CALL then RET with NPC=8'h3C → RET gives `done`+`pc_load` two cycles after accept, `pop_data`=3C, sp back to FF.
- 64 back-to-back PUSHes then a 65th → 65th gives no `mem_wr`, `done`+`err`, `ovf`=1, sp=BF unchanged; `err_clr` → `ovf`=0.
- POP on an empty stack → `done`+`err` next cycle, `udf`=1, sp=FF, no `pc_load`.
- `st_wr` and `req_valid`(PUSH) in the same cycle → PUSH wins with `st_ready`=0; the held store is granted next cycle with `sel_sp`=0, `sel_rn`=1, `mem_wr`=1.
- `rst_n` low during POP_RD → sp=FF, state IDLE, no `done` pulse.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller: request op encoding and FSM state type.
package stack_pkg;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    typedef enum logic {
        StIdle,
        StPopRd
    } state_e;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer and occupancy counter; empty-descending stack with full/empty status.
module stack_ptr
    import stack_pkg::*;
#(
    parameter logic [7:0]  SP_TOP = 8'hFF,
    parameter int unsigned DEPTH  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] sp,
    output logic       full,
    output logic       empty
);

    localparam logic [8:0] DepthMax = 9'(DEPTH);

    logic [7:0] sp_q, sp_d;
    logic [8:0] depth_q, depth_d;

    assign full  = (depth_q == DepthMax);
    assign empty = (depth_q == 9'd0);
    assign sp    = sp_q;

    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        if (push && !full) begin
            sp_d    = sp_q - 8'd1;
            depth_d = depth_q + 9'd1;
        end else if (pop && !empty) begin
            sp_d    = sp_q + 8'd1;
            depth_d = depth_q - 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= SP_TOP;
            depth_q <= 9'd0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/stack_ctrl.sv
// Stack port sequencer: PUSH/POP/CALL/RET with overflow/underflow guard, arbitrated
// against R0-addressed register stores for the data memory's single port.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter logic [7:0]  SP_TOP = 8'hFF,
    parameter int unsigned DEPTH  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    input  logic       st_wr,
    output logic       st_ready,
    input  logic [7:0] mem_rdata,
    output logic [7:0] sp,
    output logic       mem_wr,
    output logic       sel_sp,
    output logic       sel_rn,
    output logic       done,
    output logic       err,
    output logic [7:0] pop_data,
    output logic       pc_load,
    output logic       ovf,
    output logic       udf,
    input  logic       err_clr
);

    state_e state_q, state_d;

    logic       full, empty;
    logic       accept, is_push_op, is_pop_op;
    logic       push_ok, pop_ok, push_rej, pop_rej;
    logic       done_q, err_q, pc_load_q, ovf_q, udf_q, ret_q;
    logic [7:0] pop_data_q;

    stack_ptr #(
        .SP_TOP (SP_TOP),
        .DEPTH  (DEPTH)
    ) u_stack_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop_ok),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    assign is_push_op = (req_op == OP_PUSH) || (req_op == OP_CALL);
    assign is_pop_op  = (req_op == OP_POP) || (req_op == OP_RET);

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign push_ok   = accept && is_push_op && !full;
    assign pop_ok    = accept && is_pop_op && !empty;
    assign push_rej  = accept && is_push_op && full;
    assign pop_rej   = accept && is_pop_op && empty;
    // A pending stack request always beats a register store.
    assign st_ready  = st_wr && req_ready && !req_valid;

    always_comb begin
        state_d = state_q;
        mem_wr  = 1'b0;
        sel_sp  = 1'b0;
        sel_rn  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (push_ok) begin
                    mem_wr = 1'b1;
                    sel_sp = 1'b1;
                    sel_rn = (req_op == OP_PUSH);
                end else if (st_ready) begin
                    mem_wr = 1'b1;
                    sel_rn = 1'b1;
                end
                if (pop_ok) begin
                    state_d = StPopRd;
                end
            end
            StPopRd: begin
                sel_sp  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pc_load_q  <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            ret_q      <= 1'b0;
            pop_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            done_q    <= push_ok || push_rej || pop_rej || (state_q == StPopRd);
            err_q     <= push_rej || pop_rej;
            pc_load_q <= (state_q == StPopRd) && ret_q;
            if (pop_ok) begin
                ret_q <= (req_op == OP_RET);
            end
            if (state_q == StPopRd) begin
                pop_data_q <= mem_rdata;
            end
            // Set beats a same-cycle clear so no error event is lost.
            if (push_rej) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (pop_rej) begin
                udf_q <= 1'b1;
            end else if (err_clr) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign pc_load  = pc_load_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;
    assign pop_data = pop_data_q;

endmodule
